// File: rtl/egd_param_if.sv
// egd_param_if: serial code-bit input and decoded-symbol output of the Exp-Golomb decoder
interface egd_param_if #(parameter int DW = 4);
  logic si_valid;
  logic si_data;
  logic signed_mode;
  logic valid;
  logic [DW-1:0] po_data;
  logic busy;
  logic err;
  modport master (output si_valid, si_data, signed_mode, input valid, po_data, busy, err);
  modport slave (input si_valid, si_data, signed_mode, output valid, po_data, busy, err);
endinterface

// File: rtl/egd_param.sv
// egd_param: serial Exp-Golomb decoder (prefix up to MAX_M, order K); EGD_SIGNED_EN builds the se(v) mapping
module egd_param #(
  parameter int MAX_M = 3,
  parameter int K = 0
) (
  input logic clk,
  input logic rst,
  egd_param_if.slave bus
);
  localparam int DW = MAX_M + K + 1;
  localparam int MW = $clog2(MAX_M + 1);
  localparam int CW = $clog2(MAX_M + K + 1);
  typedef enum logic {PREFIX, SUFFIX} state_t;
  state_t state;
  logic [MW-1:0] m;
  logic [CW-1:0] sfx_cnt;
  logic [DW-2:0] info;
  logic [DW-1:0] info_nx;
  logic [DW-1:0] n;
  logic [DW-1:0] sym;
  logic [DW:0] code;
  logic valid;
  logic err;
  logic busy;
  logic [DW-1:0] po_data;
  logic unused_ok;
  // codeNum of the codeword if the bit on the bus is its last one; info is zero while in PREFIX
  always_comb begin
    info_nx = {info, bus.si_data};
    code = ((((DW+1)'(1) << m) - (DW+1)'(1)) << K) + {1'b0, info_nx};
    n = code[DW-1:0];
  end
`ifdef EGD_SIGNED_EN
  // se(v): odd n maps to +(n+1)/2, even n to -(n/2)
  always_comb sym = !bus.signed_mode ? n : n[0] ? (n >> 1) + DW'(1) : DW'(0) - (n >> 1);
  assign unused_ok = code[DW];
`else
  assign sym = n;
  assign unused_ok = ^{code[DW], bus.signed_mode};
`endif
  // decoder FSM: count prefix ones, then shift in m+K info bits; outputs are registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PREFIX;
      m <= '0;
      info <= '0;
      sfx_cnt <= '0;
      valid <= 1'b0;
      err <= 1'b0;
      busy <= 1'b0;
      po_data <= '0;
    end else begin
      valid <= 1'b0;
      err <= 1'b0;
      if (bus.si_valid) begin
        if (state == PREFIX) begin
          if (!bus.si_data) begin
            if (K == 0 && m == '0) begin
              valid <= 1'b1;
              po_data <= sym;
              busy <= 1'b0;
              info <= '0;
            end else begin
              state <= SUFFIX;
              sfx_cnt <= CW'(int'(m) + K);
              info <= '0;
              busy <= 1'b1;
            end
          end else if (m == MW'(MAX_M)) begin
            m <= '0;
            err <= 1'b1;
            busy <= 1'b0;
          end else begin
            m <= m + MW'(1);
            busy <= 1'b1;
          end
        end else if (sfx_cnt == CW'(1)) begin
          state <= PREFIX;
          m <= '0;
          info <= '0;
          sfx_cnt <= '0;
          valid <= 1'b1;
          po_data <= sym;
          busy <= 1'b0;
        end else begin
          info <= info_nx[DW-2:0];
          sfx_cnt <= sfx_cnt - CW'(1);
        end
      end
    end
  end
  assign bus.valid = valid;
  assign bus.err = err;
  assign bus.busy = busy;
  assign bus.po_data = po_data;
endmodule

// File: tb/tb_egd_param.sv
// tb_egd_param: randomized and directed checks of egd_param (3,0) and (2,1) against an encoder-based model
module tb_egd_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  egd_param_if #(.DW(4)) b0 ();
  egd_param_if #(.DW(4)) b1 ();
  egd_param #(.MAX_M(3), .K(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  egd_param #(.MAX_M(2), .K(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
`ifdef EGD_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  int errors = 0;
  int checks = 0;
  logic [3:0] exp_po [2];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic logic [3:0] sym_of(input int n, input bit sm);
    int s;
    s = (sm && SIGNED_EN) ? ((n % 2 == 1) ? (n + 1) / 2 : -(n / 2)) : n;
    return 4'(s);
  endfunction
  task automatic step(input int sel, input bit v, input bit d, input bit sm, input bit ev, input bit ee, input bit eb);
    b0.si_valid = (sel == 0) && v;
    b0.si_data = d;
    b0.signed_mode = sm;
    b1.si_valid = (sel == 1) && v;
    b1.si_data = d;
    b1.signed_mode = sm;
    @(posedge clk);
    #1;
    chk("valid", sel ? b1.valid : b0.valid, ev);
    chk("err", sel ? b1.err : b0.err, ee);
    chk("busy", sel ? b1.busy : b0.busy, eb);
    chk("po_data", sel ? b1.po_data : b0.po_data, exp_po[sel]);
  endtask
  task automatic idle(input int sel, input int cyc);
    for (int j = 0; j < cyc; j++) step(sel, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 0);
  endtask
  task automatic send_code(input int sel, input int n, input int gap, input bit rgap, input int smode);
    int kk;
    int m;
    int info;
    int g;
    bit last;
    bit sm;
    bit bits[$];
    kk = sel ? 1 : 0;
    m = 0;
    while (n + (1 << kk) >= (1 << (m + kk + 1))) m++;
    info = n + (1 << kk) - (1 << (m + kk));
    for (int i = 0; i < m; i++) bits.push_back(1'b1);
    bits.push_back(1'b0);
    for (int i = m + kk - 1; i >= 0; i--) bits.push_back(1'((info >> i) & 1));
    for (int i = 0; i < bits.size(); i++) begin
      g = rgap ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0) : (i > 0 ? gap : 0);
      for (int j = 0; j < g; j++) step(sel, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, i > 0);
      sm = (smode == 2) ? 1'($urandom_range(0, 1)) : smode[0];
      last = (i == bits.size() - 1);
      if (last) exp_po[sel] = sym_of(n, sm);
      step(sel, 1, bits[i], sm, last, 0, !last);
    end
  endtask
  task automatic send_ovf(input int sel);
    int mm;
    mm = sel ? 2 : 3;
    for (int i = 0; i <= mm; i++) step(sel, 1, 1, 0, 0, i == mm, i < mm);
  endtask
  initial begin
    exp_po[0] = '0;
    exp_po[1] = '0;
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    foreach (exp_po[s]) exp_po[s] = '0;
    send_code(0, 0, 0, 0, 0);
    send_code(0, 2, 0, 0, 0);
    send_code(0, 6, 0, 0, 0);
    send_code(0, 14, 0, 0, 0);
    send_ovf(0);
    send_code(0, 0, 0, 0, 0);
    send_code(0, 1, 0, 0, 1);
    send_code(0, 2, 0, 0, 1);
    send_code(1, 1, 0, 0, 0);
    send_code(1, 5, 0, 0, 0);
    send_code(1, 13, 0, 0, 0);
    send_ovf(1);
    send_code(1, 0, 0, 0, 0);
    send_code(0, 6, 3, 0, 0);
    idle(0, 3);
    step(0, 1, 1, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    rst = 1'b1;
    exp_po[0] = '0;
    exp_po[1] = '0;
    step(0, 1, 0, 0, 0, 0, 0);
    rst = 1'b0;
    send_code(0, 0, 0, 0, 0);
    for (int t = 0; t < 300; t++) begin
      int sel;
      sel = int'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) send_ovf(sel);
      else send_code(sel, int'($urandom_range(0, sel ? 13 : 14)), 0, 1, 2);
    end
    idle(0, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/egd_param.md
# egd_param

Parametrised serial Exponential-Golomb decoder and successor of the fixed 4-bit order-0 decoder. It accepts one code bit per qualified cycle and decodes prefix lengths up to `MAX_M` and Golomb order `K`. Back-to-back codewords decode with no idle bubble, and illegal prefixes raise an error pulse and resynchronise. It sits between the serial bitstream front end and the symbol consumer.

## Interface
- `MAX_M`, default 3: maximum prefix length (number of leading '1's), ≥1.
- `K`, default 0: Exp-Golomb order, ≥0.
- `DW` (localparam) = `MAX_M+K+1`: output width.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `si_valid`  in  1  qualifies `si_data`; a bit is consumed only when high.
- `si_data`  in  1  serial code bit.
- `signed_mode`  in  1  0 = ue(v) output, 1 = se(v) output; sampled when the last bit of a codeword is consumed.
- `valid`  out  1  one-cycle pulse: `po_data` holds a new symbol.
- `po_data`  out  DW  decoded symbol; holds its value until the next `valid`.
- `busy`  out  1  high while a codeword is partially received.
- `err`  out  1  one-cycle pulse: prefix overflow detected.

## Operation
- Code format: m '1's, then a terminating '0', then m+K info bits, MSB first. Here m ≤ `MAX_M`.
- codeNum = (2^m − 1)·2^K + info. The maximum value is 2^DW − 2^K − 1 and always fits DW bits. Compute internally in DW+1 bits and truncate to DW.
- FSM states:
  - PREFIX: count consumed '1's in `m` (width clog2(MAX_M+1)).
    - '0' with m+K = 0 goes to PREFIX and emits the symbol.
    - '0' otherwise goes to SUFFIX, with `sfx_cnt` = m+K.
    - '1' when m = `MAX_M` goes to PREFIX with m cleared and pulses `err`. The offending bit is discarded.
  - SUFFIX: shift each consumed bit into `info`, MSB first, and decrement `sfx_cnt`. Consuming the last bit emits the symbol and returns to PREFIX with m = 0.
- Cycles with `si_valid` = 0 change no state (stall). Gaps may occur anywhere, including inside the prefix.
- Emit: register `po_data` and pulse `valid` on the edge after the last bit is consumed.
- se(v) mapping (only with the macro, see Configuration): codeNum n odd gives +(n+1)/2; n even gives −(n/2), two's complement in DW bits.
- `busy` = (state == SUFFIX) or (m ≠ 0). It is registered and reflects state after each edge.
- Reset values: `valid` = 0, `po_data` = 0, `busy` = 0, `err` = 0, state = PREFIX, m = 0, `info` = 0, `sfx_cnt` = 0.

## Timing
- Latency: last bit consumed at edge t; `valid` and `po_data` are visible after edge t and clear after edge t+1. This holds unless the next codeword also completes at edge t+1, e.g. a '0' with K = 0 gives consecutive `valid` pulses.
- Throughput: one bit per cycle sustained. A new codeword's first bit may be consumed in the cycle right after the previous codeword's last bit.
- `err` and `valid` are never high in the same cycle.
- `rst` overrides everything: a reset asserted mid-codeword discards the partial codeword, and no `valid` or `err` follows.
- `signed_mode` changes mid-codeword take effect only at the final bit.

## Configuration
- `EGD_SIGNED_EN` defined: the se(v) mapping logic is built and `signed_mode` = 1 selects it.
- `EGD_SIGNED_EN` undefined: the mapping logic is absent, `signed_mode` is ignored (tied internally to 0), and output is always ue(v).

## Test plan
1. Defaults (MAX_M = 3, K = 0), unsigned. Bits 0 | 101 | 11011 | 1110111, contiguous `si_valid` → `valid` pulses with `po_data` 0, 2, 6, 14. The first pulse comes one cycle after the first bit, with no bubble between codewords.
2. Defaults, bits 1111 then 0 → `err` pulses once, one cycle after the 4th '1'. The following '0' yields `valid` with 0; `busy` is low after the error.
3. Defaults, `EGD_SIGNED_EN` defined, `signed_mode` = 1. Codewords 100 (n = 1) and 101 (n = 2) → `po_data` 4'h1, then 4'hF. With the macro undefined the same stimulus gives 1, then 2.
4. MAX_M = 2, K = 1 (DW = 4). Bits 01 | 1011 | 110111 → `po_data` 1, 5, 13.
5. Defaults, codeword 11011 with `si_valid` dropped for 3 cycles after each bit → `po_data` = 6, one cycle after the last valid bit. `busy` stays high throughout the gaps.
6. Defaults, bits 110 then `rst` for 1 cycle, then 0 → no `valid` during reset; after reset `valid` with `po_data` = 0, and `busy` = 0 after reset.
